// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue: the queue entry
// layout, the fetch FSM states and the byte size of one cache fetch block.
package fetch_pkg;

  localparam int WORD_BYTES = 4;

  // One buffered instruction together with its PC and fetch-fault flag
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH,
    HALT
  } fetch_state_t;

  // Byte size of one aligned fetch block of fetchWords instructions
  function automatic logic [31:0] blockBytes(input int fetchWords);
    return 32'(fetchWords * WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_ring.sv
// Circular storage behind the fetch queue: DEPTH entries, up to FETCH_WORDS
// in-order writes and ISSUE_WIDTH in-order reads per cycle, with head/tail
// pointers and an occupancy count. flush_i empties the ring in one cycle.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int FETCH_WORDS = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  localparam int PTRW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1),
  localparam int WCW  = $clog2(FETCH_WORDS + 1),
  localparam int TKW  = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic [WCW-1:0]                      wrCount_i,
  input  fetch_entry_t [FETCH_WORDS-1:0]      wrData_i,
  input  logic [TKW-1:0]                      take_i,
  output fetch_entry_t [ISSUE_WIDTH-1:0]      rdData_o,
  output logic [CNTW-1:0]                     count_o
);

  fetch_entry_t            entries_q [DEPTH];
  logic [PTRW-1:0]         head_q;
  logic [PTRW-1:0]         tail_q;
  logic [CNTW-1:0]         count_q;

  // Pointer and occupancy bookkeeping; a flush drops everything at once
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTRW'(wrCount_i);
      head_q  <= head_q + PTRW'(take_i);
      count_q <= count_q + CNTW'(wrCount_i) - CNTW'(take_i);
    end
  end

  // Entry storage has no reset; stale contents are never exposed past count
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WORDS; k++) begin
      if (!reset && !flush_i && k < int'(wrCount_i)) begin
        entries_q[tail_q + PTRW'(k)] <= wrData_i[k];
      end
    end
  end

  // Read ports present the oldest ISSUE_WIDTH entries starting at head
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      rdData_o[i] = entries_q[head_q + PTRW'(i)];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue for the superscalar front end. Requests aligned
// fetch blocks, skips the words before an unaligned redirect target, buffers
// instructions with their PCs and presents up to ISSUE_WIDTH per cycle.
// Optional build macro FETCH_ADDR_CHECK_EN turns a branch target with nonzero
// low two bits into a single fetch-exception entry instead of fetching.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          FETCH_WORDS = 2,
  parameter int          ISSUE_WIDTH = 2,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] FLUSH_PC    = 32'h0000_0000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                Flush,
  input  logic                                Branch,
  input  logic [31:0]                         PCBranch,
  output logic [31:0]                         Addr,
  output logic                                AddrValid,
  input  logic [32*FETCH_WORDS-1:0]           Instr,
  input  logic                                InstrValid,
  input  logic                                TLBException,
  output logic [ISSUE_WIDTH-1:0]              IssueValid,
  output logic [32*ISSUE_WIDTH-1:0]           IssuePC,
  output logic [32*ISSUE_WIDTH-1:0]           IssueInstr,
  output logic [ISSUE_WIDTH-1:0]              IssueExc,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]    Take
);

  localparam int          TKW         = $clog2(ISSUE_WIDTH + 1);
  localparam int          CNTW        = $clog2(DEPTH + 1);
  localparam int          WCW         = $clog2(FETCH_WORDS + 1);
  localparam int          OFFW        = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1;
  localparam logic [31:0] BLOCK_BYTES = blockBytes(FETCH_WORDS);
  localparam logic [31:0] BLOCK_MASK  = ~(BLOCK_BYTES - 32'd1);

  // Word index of an address inside its fetch block
  function automatic logic [OFFW-1:0] wordIdx(input logic [31:0] a);
    return (FETCH_WORDS > 1) ? a[2 +: OFFW] : '0;
  endfunction

  fetch_state_t                  state_q;
  logic [31:0]                   addr_q;
  logic [OFFW-1:0]               offset_q;
`ifdef FETCH_ADDR_CHECK_EN
  logic                          excPend_q;
  logic [31:0]                   excPc_q;
`endif

  logic                          redirect;
  logic [31:0]                   target;
  logic                          accept;
  logic                          tlbHalt;
  logic [WCW-1:0]                wrCount;
  fetch_entry_t [FETCH_WORDS-1:0] wrData;
  logic [TKW-1:0]                takeEff;
  fetch_entry_t [ISSUE_WIDTH-1:0] rdData;
  logic [CNTW-1:0]               ringCount;
  int                            freeSlots;
  int                            needWords;
  int                            j;

  assign redirect = Flush | Branch;
  assign target   = Flush ? FLUSH_PC : PCBranch;

  // Decide what enters the queue this cycle: a fetched block trimmed by the
  // skip offset, or one exception entry. Space is judged on the count at the
  // start of the cycle, so same-cycle dequeues never make room early.
  always_comb begin
    freeSlots = DEPTH - int'(ringCount);
    needWords = FETCH_WORDS - int'(offset_q);
    j         = 0;
    accept    = 1'b0;
    tlbHalt   = 1'b0;
    wrCount   = '0;
    wrData    = '0;
    if (!redirect) begin
`ifdef FETCH_ADDR_CHECK_EN
      if (excPend_q) begin
        wrCount   = WCW'(1);
        wrData[0] = '{pc: excPc_q, instr: 32'h0, exc: 1'b1};
      end
`endif
      if (state_q == FETCH && InstrValid) begin
        if (TLBException) begin
          if (freeSlots >= 1) begin
            tlbHalt   = 1'b1;
            wrCount   = WCW'(1);
            wrData[0] = '{pc: addr_q + 32'(4 * int'(offset_q)), instr: 32'h0, exc: 1'b1};
          end
        end else if (freeSlots >= needWords) begin
          accept  = 1'b1;
          wrCount = WCW'(needWords);
          for (int k = 0; k < FETCH_WORDS; k++) begin
            j = int'(offset_q) + k;
            if (j < FETCH_WORDS) begin
              wrData[k] = '{pc: addr_q + 32'(4 * j), instr: Instr[32*j +: 32], exc: 1'b0};
            end
          end
        end
      end
    end
  end

  // Decode may never take more than is valid; an overrun is clipped here
  always_comb begin
    takeEff = Take;
    if (redirect) begin
      takeEff = '0;
    end else if (int'(Take) > int'(ringCount)) begin
      takeEff = TKW'(ringCount);
    end
  end

  // Fetch FSM: block address, skip offset and the halt on fetch faults
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      addr_q   <= RESET_PC & BLOCK_MASK;
      offset_q <= wordIdx(RESET_PC);
`ifdef FETCH_ADDR_CHECK_EN
      excPend_q <= 1'b0;
      excPc_q   <= 32'h0;
`endif
    end else if (redirect) begin
      addr_q   <= target & BLOCK_MASK;
      offset_q <= wordIdx(target);
`ifdef FETCH_ADDR_CHECK_EN
      if (!Flush && PCBranch[1:0] != 2'b00) begin
        state_q   <= HALT;
        excPend_q <= 1'b1;
        excPc_q   <= PCBranch;
      end else begin
        state_q   <= FETCH;
        excPend_q <= 1'b0;
      end
`else
      state_q  <= FETCH;
`endif
    end else begin
`ifdef FETCH_ADDR_CHECK_EN
      excPend_q <= 1'b0;
`endif
      if (tlbHalt) begin
        state_q <= HALT;
      end else if (accept) begin
        addr_q   <= addr_q + BLOCK_BYTES;
        offset_q <= '0;
      end
    end
  end

  // Flags a decode stage that consumes more slots than are valid
  always_ff @(posedge clk) begin
    if (!reset && !redirect) begin
      assert (int'(Take) <= int'(ringCount));
    end
  end

  fetch_ring #(
    .FETCH_WORDS (FETCH_WORDS),
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .DEPTH       (DEPTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (redirect),
    .wrCount_i (wrCount),
    .wrData_i  (wrData),
    .take_i    (takeEff),
    .rdData_o  (rdData),
    .count_o   (ringCount)
  );

  assign Addr      = addr_q;
  assign AddrValid = (state_q == FETCH);

  // Issue slots are a thermometer over the occupancy; empty slots read as 0
  always_comb begin
    IssueValid = '0;
    IssuePC    = '0;
    IssueInstr = '0;
    IssueExc   = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (i < int'(ringCount)) begin
        IssueValid[i]         = 1'b1;
        IssuePC[32*i +: 32]    = rdData[i].pc;
        IssueInstr[32*i +: 32] = rdData[i].instr;
        IssueExc[i]           = rdData[i].exc;
      end
    end
  end

endmodule
